// File: rtl/order_issuer_pkg.sv
// Shared types for the order-issue path: FSM states, side encoding and the order payload.
package trade_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        COOLDOWN = 2'd2
    } order_state_t;

    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    typedef struct packed {
        logic       side;
        logic [7:0] price;
        logic [7:0] qty;
    } order_t;

    // Sign-extend a 16-bit position so limit arithmetic cannot overflow.
    function automatic logic signed [16:0] sext17(input logic [15:0] v);
        return $signed({v[15], v});
    endfunction

endpackage

// File: rtl/order_issuer_if.sv
// Valid/ready order port between the order issuer and the downstream exchange logic.
interface order_if;
    logic       order_valid;
    logic       order_ready;
    logic       order_side;
    logic [7:0] order_price;
    logic [7:0] order_qty;

    modport master (
        output order_valid,
        output order_side,
        output order_price,
        output order_qty,
        input  order_ready
    );

    modport slave (
        input  order_valid,
        input  order_side,
        input  order_price,
        input  order_qty,
        output order_ready
    );
endinterface

// File: rtl/order_issuer_edge_detect.sv
// Rising-edge detector for a level signal; the delayed copy clears on asynchronous active-low reset.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/order_issuer.sv
// Turns level buy/sell indications into single valid/ready orders, enforcing a
// symmetric position limit and a post-order cooldown, and counting dropped events.
module order_issuer
    import trade_pkg::*;
#(
    parameter logic        [7:0]  QTY             = 8'd1,
    parameter logic signed [15:0] MAX_POS         = 16'sd100,
    parameter logic        [7:0]  COOLDOWN_CYCLES = 8'd16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               buy_signal,
    input  logic               sell_signal,
    input  logic [7:0]         current_data,
    order_if.master            ord,
    output logic signed [15:0] position,
    output logic [7:0]         drop_count,
    output logic               busy
);

    order_state_t       state_reg, state_next;
    logic [7:0]         cnt_reg, cnt_next;
    logic               side_reg, side_next;
    logic [7:0]         price_reg, price_next;
    logic signed [15:0] position_reg, position_next;
    logic [7:0]         drop_count_reg, drop_count_next;
    logic               drop_evt;

    logic [1:0] lvl;
    logic [1:0] evt;
    logic       buy_evt;
    logic       sell_evt;

    assign lvl = {sell_signal, buy_signal};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            edge_detect u_edge (
                .clk  (clk),
                .rst  (rst),
                .sig  (lvl[gi]),
                .rise (evt[gi])
            );
        end
    endgenerate

    assign buy_evt  = evt[0];
    assign sell_evt = evt[1];

    // Limit check in 17 bits so position +/- QTY is exact at the boundary.
    logic signed [16:0] pos_ext;
    logic signed [16:0] qty_ext;
    logic signed [16:0] max_ext;
    logic signed [15:0] qty16;
    logic               buy_ok;
    logic               sell_ok;

    assign pos_ext = sext17(position_reg);
    assign qty_ext = $signed({9'd0, QTY});
    assign max_ext = sext17(MAX_POS);
    assign qty16   = $signed({8'd0, QTY});
    assign buy_ok  = (pos_ext + qty_ext) <= max_ext;
    assign sell_ok = (pos_ext - qty_ext) >= -max_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 8'd0;
            side_reg       <= SIDE_BUY;
            price_reg      <= 8'd0;
            position_reg   <= 16'sd0;
            drop_count_reg <= 8'd0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            side_reg       <= side_next;
            price_reg      <= price_next;
            position_reg   <= position_next;
            drop_count_reg <= drop_count_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        side_next     = side_reg;
        price_next    = price_reg;
        position_next = position_reg;
        drop_evt      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (buy_evt && sell_evt) begin
                    drop_evt = 1'b1;
                end else if (buy_evt) begin
                    if (buy_ok) begin
                        side_next  = SIDE_BUY;
                        price_next = current_data;
                        state_next = ISSUE;
                    end else begin
                        drop_evt = 1'b1;
                    end
                end else if (sell_evt) begin
                    if (sell_ok) begin
                        side_next  = SIDE_SELL;
                        price_next = current_data;
                        state_next = ISSUE;
                    end else begin
                        drop_evt = 1'b1;
                    end
                end
            end

            ISSUE: begin
                drop_evt = buy_evt | sell_evt;
                // order_valid is high throughout ISSUE, so ready alone completes the handshake.
                if (ord.order_ready) begin
                    position_next = (side_reg == SIDE_BUY) ? position_reg + qty16
                                                           : position_reg - qty16;
                    if (COOLDOWN_CYCLES == 8'd0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = COOLDOWN;
                        cnt_next   = COOLDOWN_CYCLES;
                    end
                end
            end

            COOLDOWN: begin
                drop_evt = buy_evt | sell_evt;
                if (cnt_reg <= 8'd1) begin
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase

        if (drop_evt && (drop_count_reg != 8'hFF)) begin
            drop_count_next = drop_count_reg + 8'd1;
        end else begin
            drop_count_next = drop_count_reg;
        end
    end

    order_t cur_order;

    always_comb begin
        cur_order       = '{side: side_reg, price: price_reg, qty: QTY};
        ord.order_valid = (state_reg == ISSUE);
        ord.order_side  = cur_order.side;
        ord.order_price = cur_order.price;
        ord.order_qty   = cur_order.qty;
        busy            = (state_reg != IDLE);
        position        = position_reg;
        drop_count      = drop_count_reg;
    end

endmodule

// File: tb/tb_order_issuer.sv
// Randomised bench for order_issuer: a queue scoreboard checks order payloads,
// while a cycle-level reference model checks position, drop count, busy and valid.
module tb_order_issuer;
    import trade_pkg::*;

    localparam int Q    = 1;
    localparam int MAXP = 2;
    localparam int COOL = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               buy_signal = 1'b0;
    logic               sell_signal = 1'b0;
    logic [7:0]         current_data = 8'd0;
    logic signed [15:0] position;
    logic [7:0]         drop_count;
    logic               busy;

    order_if ord_bus ();

    order_issuer #(
        .QTY             (8'(Q)),
        .MAX_POS         (16'(MAXP)),
        .COOLDOWN_CYCLES (8'(COOL))
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .buy_signal   (buy_signal),
        .sell_signal  (sell_signal),
        .current_data (current_data),
        .ord          (ord_bus.master),
        .position     (position),
        .drop_count   (drop_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    order_t exp_q[$];

    // Reference model: an outstanding order flag, cycles of cooldown left, and counters.
    bit m_has_order;
    bit m_side;
    int m_cool;
    int m_pos;
    int m_drops;
    bit m_prev_b;
    bit m_prev_s;

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_has_order = 1'b0;
        m_side      = 1'b0;
        m_cool      = 0;
        m_pos       = 0;
        m_drops     = 0;
        m_prev_b    = 1'b0;
        m_prev_s    = 1'b0;
    endtask

    task automatic model_accept(input bit side, input logic [7:0] d);
        order_t o;
        o.side  = side;
        o.price = d;
        o.qty   = 8'(Q);
        m_has_order = 1'b1;
        m_side      = side;
        exp_q.push_back(o);
    endtask

    task automatic model_step(input bit b, input bit s, input logic [7:0] d, input bit rdy);
        bit be;
        bit se;
        bit drop;
        be   = b && !m_prev_b;
        se   = s && !m_prev_s;
        drop = 1'b0;
        if (m_has_order) begin
            drop = be || se;
            if (rdy) begin
                m_pos       = m_side ? m_pos - Q : m_pos + Q;
                m_has_order = 1'b0;
                m_cool      = COOL;
            end
        end else if (m_cool > 0) begin
            drop   = be || se;
            m_cool = m_cool - 1;
        end else if (be && se) begin
            drop = 1'b1;
        end else if (be) begin
            if (m_pos + Q <= MAXP) model_accept(1'b0, d);
            else drop = 1'b1;
        end else if (se) begin
            if (m_pos - Q >= -MAXP) model_accept(1'b1, d);
            else drop = 1'b1;
        end
        if (drop && m_drops < 255) m_drops++;
        m_prev_b = b;
        m_prev_s = s;
    endtask

    // Called just after a rising edge: drive, check at the falling edge, advance the model.
    task automatic cycle(input bit b, input bit s, input logic [7:0] d, input bit rdy);
        buy_signal            = b;
        sell_signal           = s;
        current_data          = d;
        ord_bus.order_ready   = rdy;
        @(negedge clk);
        check_int("position", int'(position), m_pos);
        check_int("drop_count", int'(drop_count), m_drops);
        check_int("busy", int'(busy), int'(m_has_order || (m_cool > 0)));
        check_int("order_valid", int'(ord_bus.order_valid), int'(m_has_order));
        model_step(b, s, d, rdy);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every presented order must match the oldest accepted event.
    always @(negedge clk) begin
        if (rst && ord_bus.order_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL order_unexpected: got side=%0d price=%0d, expected no order at %0t",
                         ord_bus.order_side, ord_bus.order_price, $time);
            end else begin
                if (ord_bus.order_side !== exp_q[0].side || ord_bus.order_price !== exp_q[0].price ||
                    ord_bus.order_qty !== exp_q[0].qty) begin
                    n_err++;
                    $display("FAIL order_payload: got side=%0d price=%0d qty=%0d, expected side=%0d price=%0d qty=%0d at %0t",
                             ord_bus.order_side, ord_bus.order_price, ord_bus.order_qty,
                             exp_q[0].side, exp_q[0].price, exp_q[0].qty, $time);
                end
                if (ord_bus.order_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        bit rb;
        bit rs;
        ord_bus.order_ready = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_int("reset_valid", int'(ord_bus.order_valid), 0);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_position", int'(position), 0);
        check_int("reset_drops", int'(drop_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Buy at price 42 with ready high, then the full cooldown
        cycle(1'b0, 1'b0, 8'd0, 1'b1);
        cycle(1'b1, 1'b0, 8'd42, 1'b1);
        repeat (20) cycle(1'b1, 1'b0, 8'($urandom), 1'b1);

        // Sell with ready held low for five cycles while the price moves
        cycle(1'b0, 1'b0, 8'd0, 1'b0);
        cycle(1'b0, 1'b1, 8'd77, 1'b0);
        repeat (5) cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
        cycle(1'b0, 1'b1, 8'($urandom), 1'b1);
        repeat (18) cycle(1'b0, 1'b0, 8'($urandom), 1'b1);

        // Simultaneous buy and sell edges
        cycle(1'b1, 1'b1, 8'd9, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 8'($urandom), 1'b1);

        // Buy held across ISSUE/COOLDOWN with a sell edge during cooldown
        cycle(1'b1, 1'b0, 8'd30, 1'b1);
        repeat (4) cycle(1'b1, 1'b0, 8'($urandom), 1'b1);
        repeat (22) cycle(1'b1, 1'b1, 8'($urandom), 1'b1);
        cycle(1'b0, 1'b0, 8'd0, 1'b1);
        cycle(1'b0, 1'b1, 8'd50, 1'b1);
        repeat (20) cycle(1'b0, 1'b0, 8'($urandom), 1'b1);

        // Three buys against the limit of 2: the third is dropped
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 8'(60 + k), 1'b1);
            repeat (20) cycle(1'b0, 1'b0, 8'($urandom), 1'b1);
        end

        // Reset while an order is being presented
        cycle(1'b0, 1'b0, 8'd0, 1'b0);
        cycle(1'b0, 1'b1, 8'd55, 1'b0);
        #2;
        rst         = 1'b0;
        sell_signal = 1'b0;
        #1;
        check_int("rst_async_valid", int'(ord_bus.order_valid), 0);
        check_int("rst_async_position", int'(position), 0);
        check_int("rst_async_drops", int'(drop_count), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1'b1, 1'b0, 8'd99, 1'b1);
        repeat (20) cycle(1'b0, 1'b0, 8'($urandom), 1'b1);

        // Random traffic: toggling levels, ready high about 70% of cycles
        rb = 1'b0;
        rs = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) rb = ~rb;
            if ($urandom_range(3) == 0) rs = ~rs;
            cycle(rb, rs, 8'($urandom), ($urandom_range(9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/order_issuer.md
Name: order_issuer

Overview:
- Consumes the level-type buy_signal/sell_signal produced by the Z-score trade block and turns them into discrete order transactions on a valid/ready order port.
- Edge-detects the signals and latches the current price.
- Enforces a symmetric position limit and a post-order cooldown.
- Tracks net position and counts dropped trade events.
- Sits between the signal generator and the downstream order/exchange interface.

Parameters:
- QTY, 8'd1: order quantity per transaction (unsigned).
- MAX_POS, 16'sd100: absolute net-position limit (signed, must be > 0).
- COOLDOWN_CYCLES, 8'd16: idle cycles enforced after each accepted order (0 = none).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- buy_signal  input  1  level buy indication from the Z-score block
- sell_signal  input  1  level sell indication from the Z-score block
- current_data  input  8  current price sample
- order_ready  input  1  downstream accepts order this cycle
- order_valid  output  1  order payload valid
- order_side  output  1  0 = buy, 1 = sell
- order_price  output  8  latched price
- order_qty  output  8  equals QTY
- position  output  16  signed net position
- drop_count  output  8  saturating count of rejected events
- busy  output  1  high when state != IDLE

Behaviour:
- Reset (rst low, asynchronous) clears all outputs, the edge registers, and the cooldown counter to 0, and sets state to IDLE. Deassertion is synchronised by the user; no special handling inside.
- Edge detect:
  - buy_evt = buy_signal & ~buy_q; sell_evt = sell_signal & ~sell_q.
  - buy_q and sell_q update every cycle in every state, so a level held through ISSUE/COOLDOWN never fires later.
- States: IDLE, ISSUE, COOLDOWN.
- IDLE:
  - buy_evt & sell_evt same cycle: conflict. Drop, drop_count += 1, stay in IDLE.
  - buy_evt only: if position + QTY <= MAX_POS (17-bit signed compare), latch side=0 and price=current_data, go to ISSUE. Otherwise drop and count.
  - sell_evt only: if position - QTY >= -MAX_POS, latch side=1 and price, go to ISSUE. Otherwise drop and count.
  - order_valid rises the cycle after the triggering edge (latency 1 clk from event sample).
- ISSUE:
  - order_valid = 1; side, price and qty held stable until the handshake.
  - On order_valid & order_ready at a clock edge: position += QTY (buy) or -= QTY (sell). order_valid deasserts the next cycle.
  - Next state is COOLDOWN with counter = COOLDOWN_CYCLES, or IDLE if COOLDOWN_CYCLES == 0.
  - Indefinite order_ready low: stay in ISSUE, no timeout.
- COOLDOWN: counter decrements each cycle; transition to IDLE on the cycle the counter reaches 1, so exactly COOLDOWN_CYCLES cycles are spent in COOLDOWN.
- Events in ISSUE or COOLDOWN are dropped and counted.
- drop_count saturates at 8'hFF and never wraps.
- position arithmetic is 16-bit signed. The limit check guarantees |position| <= MAX_POS, so no overflow.
- order_qty is driven constant QTY; it is not registered per order.
- Reset mid-ISSUE abandons the order: order_valid drops immediately and asynchronously; position is not updated.

Decomposition:
- Shared package trade_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN} order_state_t;
  - localparam SIDE_BUY = 1'b0, SIDE_SELL = 1'b1;
  - typedef struct packed {logic side; logic [7:0] price; logic [7:0] qty;} order_t;
- One sub-module, edge_detect (rising edge, async active-low reset), instantiated twice. Limit check and FSM stay in the top.

Test Plan:
1. Reset, then buy_signal rises with current_data=8'd42, order_ready=1 -> order_valid high one cycle later with side=0, price=42, qty=1; position=1 after the handshake; busy for 1+16 cycles.
2. Sell edge with order_ready held low 5 cycles, current_data changing each cycle -> order_valid held 6 cycles, price stays at the value at the edge, position decrements by 1 only at the handshake.
3. buy_signal and sell_signal rise in the same cycle -> no order, drop_count=1, state stays IDLE.
4. MAX_POS=2: three buy edges spaced past cooldown -> two orders, position=2, third dropped, drop_count=1.
5. buy_signal held high across ISSUE and COOLDOWN, plus a sell edge during COOLDOWN -> exactly one order; sell dropped (drop_count +1); no order when returning to IDLE.
6. rst asserted low while order_valid=1 -> order_valid, position, and drop_count all 0 immediately; the next buy edge after release issues normally.
